// File: rtl/fetch_queue_unit.sv
// Fetch unit: owns the PC, keeps one memory fetch in flight, predecodes control flow and queues words.
// Build option FETCH_BHT_EN adds a 2-bit BHT for B-type direction; otherwise static BTFNT is used.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       IQ_AW    = 4,
    parameter int unsigned       BHT_AW   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_inst,
    output logic              iq_valid,
    output logic [INST_W-1:0] iq_inst,
    output logic [ADDR_W-1:0] iq_pc,
    output logic              iq_pred_taken,
    output logic [ADDR_W-1:0] iq_pred_pc,
    input  logic              iq_pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken
);

    localparam int unsigned    IqDepth  = 1 << IQ_AW;
    localparam logic [IQ_AW:0] IqFull   = (IQ_AW + 1)'(IqDepth);
    localparam logic [6:0]     OpJal    = 7'b1101111;
    localparam logic [6:0]     OpJalr   = 7'b1100111;
    localparam logic [6:0]     OpBranch = 7'b1100011;

    typedef enum logic [1:0] {StIdle, StWait, StHalt, StDrop} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IQ_AW-1:0]  head_q, head_d;
    logic [IQ_AW-1:0]  tail_q, tail_d;
    logic [IQ_AW:0]    count_q, count_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              push, pop;
    logic              iq_full, iq_empty;

    logic [INST_W-1:0] iq_inst_mem  [IqDepth];
    logic [ADDR_W-1:0] iq_pc_mem    [IqDepth];
    logic              iq_taken_mem [IqDepth];
    logic [ADDR_W-1:0] iq_npc_mem   [IqDepth];

    // Predecode of the word arriving on mem_inst, relative to the current PC.
    logic [6:0]        opcode;
    logic [20:0]       imm_j;
    logic [12:0]       imm_b;
    logic [ADDR_W-1:0] pc_plus4, pc_jal, pc_br;
    logic              br_pred;
    logic              pd_taken;
    logic [ADDR_W-1:0] pd_next;

    always_comb begin
        opcode   = mem_inst[6:0];
        imm_j    = {mem_inst[31], mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
        imm_b    = {mem_inst[31], mem_inst[7], mem_inst[30:25], mem_inst[11:8], 1'b0};
        pc_plus4 = pc_q + ADDR_W'(4);
        pc_jal   = pc_q + ADDR_W'($signed(imm_j));
        pc_br    = pc_q + ADDR_W'($signed(imm_b));
        pd_taken = 1'b0;
        pd_next  = pc_plus4;
        case (opcode)
            OpJal: begin
                pd_taken = 1'b1;
                pd_next  = pc_jal;
            end
            OpBranch: begin
                pd_taken = br_pred;
                pd_next  = br_pred ? pc_br : pc_plus4;
            end
            // Target unknown until execute; the ROB flushes to the real target.
            OpJalr:  pd_taken = 1'b1;
            default: ;
        endcase
    end

`ifdef FETCH_BHT_EN
    logic [1:0]        bht_q [1 << BHT_AW];
    logic [BHT_AW-1:0] bht_rd_idx, bht_wr_idx;
    logic              unused_upd;

    assign bht_rd_idx = pc_q[BHT_AW+1:2];
    assign bht_wr_idx = upd_pc[BHT_AW+1:2];
    assign br_pred    = bht_q[bht_rd_idx][1];
    assign unused_upd = ^{upd_pc[ADDR_W-1:BHT_AW+2], upd_pc[1:0]};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bht_q <= '{default: 2'b01};
        end else if (rdy_in && upd_valid) begin
            if (upd_taken && bht_q[bht_wr_idx] != 2'b11) begin
                bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] + 2'b01;
            end else if (!upd_taken && bht_q[bht_wr_idx] != 2'b00) begin
                bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] - 2'b01;
            end
        end
    end
`else
    logic unused_upd;

    // Backward taken, forward not taken: the immediate sign bit is the prediction.
    assign br_pred    = mem_inst[31];
    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, 32'(BHT_AW)};
`endif

    assign iq_full  = (count_q == IqFull);
    assign iq_empty = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pop        = iq_pop && !iq_empty;
        push       = 1'b0;

        case (state_q)
            StIdle: begin
                // IDLE never has a word in flight, so a free slot reserves room for it.
                if (!iq_full) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (mem_done) begin
                    push      = !iq_full || pop;
                    pc_d      = pd_next;
                    mem_req_d = 1'b0;
                    state_d   = (opcode == OpJalr) ? StHalt : StIdle;
                end
            end
            StHalt: ;
            StDrop: begin
                if (mem_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            push      = 1'b0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pc_d      = flush_pc;
            mem_req_d = 1'b0;
            // A word still owed by memory must be swallowed before fetching again.
            if (state_q == StDrop || (state_q == StWait && !mem_done)) begin
                state_d = StDrop;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            iq_inst_mem[tail_q]  <= mem_inst;
            iq_pc_mem[tail_q]    <= pc_q;
            iq_taken_mem[tail_q] <= pd_taken;
            iq_npc_mem[tail_q]   <= pd_next;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign iq_valid      = !iq_empty;
    assign iq_inst       = iq_valid ? iq_inst_mem[head_q] : '0;
    assign iq_pc         = iq_valid ? iq_pc_mem[head_q] : '0;
    assign iq_pred_taken = iq_valid ? iq_taken_mem[head_q] : 1'b0;
    assign iq_pred_pc    = iq_valid ? iq_npc_mem[head_q] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scenario bench for fetch_queue_unit: a scoreboard of expected IQ entries is filled as
// words are returned and drained as the queue head is popped.
`timescale 1ns/1ps
module tb_fetch_queue_unit;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JALR = 32'h00008067;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] pred_pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, rdy, mem_req, mem_done, iq_valid, iq_pred_taken, iq_pop;
    logic        flush, upd_valid, upd_taken;
    logic [31:0] mem_addr, mem_inst, iq_inst, iq_pc, iq_pred_pc, flush_pc, upd_pc;

    int          n_tests = 0;
    int          n_fail  = 0;
    entry_t      sb[$];
    logic [31:0] imem [logic [31:0]];

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_inst     (mem_inst),
        .iq_valid     (iq_valid),
        .iq_inst      (iq_inst),
        .iq_pc        (iq_pc),
        .iq_pred_taken(iq_pred_taken),
        .iq_pred_pc   (iq_pred_pc),
        .iq_pop       (iq_pop),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken)
    );

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return imem.exists(a) ? imem[a] : ADDI;
    endfunction

    task automatic do_reset();
        rst = 1; rdy = 1; mem_done = 0; mem_inst = 0; iq_pop = 0;
        flush = 0; flush_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        imem.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_req(output bit ok, output logic [31:0] addr);
        ok = 0;
        addr = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                ok = 1;
                addr = mem_addr;
            end
        end
    endtask

    task automatic respond(input logic [31:0] w);
        mem_inst = w;
        mem_done = 1;
        @(posedge clk); #1;
        mem_done = 0;
        mem_inst = 0;
    endtask

    task automatic pop_head(output bit ok, output entry_t e);
        ok = 0;
        e = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (iq_valid) begin
                ok = 1;
                e = '{iq_inst, iq_pc, iq_pred_taken, iq_pred_pc};
            end else begin
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            iq_pop = 1;
            @(posedge clk); #1;
            iq_pop = 0;
        end
    endtask

    task automatic count_reqs(input int cycles, output int busy);
        busy = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (mem_req) busy++;
        end
    endtask

    task automatic flush_to(input logic [31:0] target);
        flush = 1;
        flush_pc = target;
        @(posedge clk); #1;
        flush = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; mem_done = 0; mem_inst = 0; iq_pop = 0;
        flush = 0; flush_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b addr=%h v=%b inst=%h pc=%h tk=%b npc=%h want all 0",
                     mem_req, mem_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_pc);
        end
        rst = 0;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_req(ok, a);
            n_tests++;
            if (!ok || a !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_addr[%0d] got=%h seen=%b want=%h", k, a, ok, 32'(4 * k));
            end
            if (k == 0) begin
                n_tests++;
                if (iq_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq_valid_before got=%b want=0", iq_valid);
                end
            end
            if (ok) begin
                respond(word_at(a));
                sb.push_back('{ADDI, 32'(4 * k), 1'b0, 32'(4 * k + 4)});
            end
            if (k == 0) begin
                n_tests++;
                if (iq_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL seq_valid_after got=%b want=1", iq_valid);
                end
            end
        end
        repeat (3) begin
            pop_head(ok, got);
            want = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if (!ok || got !== want) begin
                n_fail++;
                $display("FAIL seq_entry got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_jal();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        logic [31:0] exp_a [4];
        exp_a = '{32'h0, 32'h4, 32'h8, 32'h18};
        do_reset();
        imem[32'h8] = enc_jal(21'd16);
        for (int k = 0; k < 4; k++) begin
            wait_req(ok, a);
            n_tests++;
            if (!ok || a !== exp_a[k]) begin
                n_fail++;
                $display("FAIL jal_addr[%0d] got=%h seen=%b want=%h", k, a, ok, exp_a[k]);
            end
            if (ok && k < 3) respond(word_at(a));
        end
        sb.push_back('{ADDI, 32'h0, 1'b0, 32'h4});
        sb.push_back('{ADDI, 32'h4, 1'b0, 32'h8});
        sb.push_back('{enc_jal(21'd16), 32'h8, 1'b1, 32'h18});
        repeat (3) begin
            pop_head(ok, got);
            want = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if (!ok || got !== want) begin
                n_fail++;
                $display("FAIL jal_entry got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_fill();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        int busy;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            wait_req(ok, a);
            n_tests++;
            if (!ok || a !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL fill_addr[%0d] got=%h seen=%b want=%h", k, a, ok, 32'(4 * k));
            end
            if (ok) respond(word_at(a));
            sb.push_back('{ADDI, 32'(4 * k), 1'b0, 32'(4 * k + 4)});
        end
        count_reqs(10, busy);
        n_tests++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL fill_full_no_req got=%0d req cycles want=0", busy);
        end
        pop_head(ok, got);
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL fill_first_pop got=%h want=%h", got, want);
        end
        wait_req(ok, a);
        n_tests++;
        if (!ok || a !== 32'h40) begin
            n_fail++;
            $display("FAIL fill_refetch got=%h seen=%b want=00000040", a, ok);
        end
        if (ok) respond(word_at(a));
        sb.push_back('{ADDI, 32'h40, 1'b0, 32'h44});
        count_reqs(10, busy);
        n_tests++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL fill_one_fetch_only got=%0d req cycles want=0", busy);
        end
        repeat (16) begin
            pop_head(ok, got);
            want = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if (!ok || got !== want) begin
                n_fail++;
                $display("FAIL fill_entry got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_jalr_halt();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        int busy;
        do_reset();
        imem[32'h20] = JALR;
        for (int k = 0; k < 9; k++) begin
            wait_req(ok, a);
            if (ok) respond(word_at(a));
            sb.push_back('{(k == 8) ? JALR : ADDI, 32'(4 * k), k == 8, 32'(4 * k + 4)});
        end
        count_reqs(10, busy);
        n_tests++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL halt_no_req got=%0d req cycles want=0", busy);
        end
        repeat (9) begin
            pop_head(ok, got);
            want = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if (!ok || got !== want) begin
                n_fail++;
                $display("FAIL halt_entry got=%h want=%h", got, want);
            end
        end
        flush_to(32'h100);
        wait_req(ok, a);
        n_tests++;
        if (!ok || a !== 32'h100) begin
            n_fail++;
            $display("FAIL halt_flush_addr got=%h seen=%b want=00000100", a, ok);
        end
    endtask

    task automatic test_flush_wait();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        do_reset();
        wait_req(ok, a);
        if (ok) respond(word_at(a));
        wait_req(ok, a);
        flush_to(32'h200);
        n_tests++;
        if (mem_req !== 1'b0 || iq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clears got req=%b valid=%b want req=0 valid=0", mem_req, iq_valid);
        end
        respond(32'h00200113);
        n_tests++;
        if (iq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop got valid=%b want 0", iq_valid);
        end
        wait_req(ok, a);
        n_tests++;
        if (!ok || a !== 32'h200) begin
            n_fail++;
            $display("FAIL flush_refetch got=%h seen=%b want=00000200", a, ok);
        end
        if (ok) respond(word_at(a));
        sb.push_back('{ADDI, 32'h200, 1'b0, 32'h204});
        pop_head(ok, got);
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL flush_entry got=%h want=%h", got, want);
        end
    endtask

    task automatic test_rdy_freeze();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        do_reset();
        wait_req(ok, a);
        rdy = 0;
        respond(JALR);
        rdy = 1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b1 || iq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_freeze got req=%b valid=%b want req=1 valid=0", mem_req, iq_valid);
        end
        respond(ADDI);
        sb.push_back('{ADDI, 32'h0, 1'b0, 32'h4});
        pop_head(ok, got);
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL rdy_entry got=%h want=%h", got, want);
        end
    endtask

`ifdef FETCH_BHT_EN
    task automatic test_branch();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        do_reset();
        imem[32'h40] = enc_b(13'd8, 3'b000);
        upd_valid = 1;
        upd_pc = 32'h40;
        upd_taken = 1;
        repeat (2) @(posedge clk);
        #1 upd_valid = 0;
        flush_to(32'h40);
        respond(ADDI);
        wait_req(ok, a);
        n_tests++;
        if (!ok || a !== 32'h40) begin
            n_fail++;
            $display("FAIL bht_fetch got=%h seen=%b want=00000040", a, ok);
        end
        if (ok) respond(word_at(a));
        sb.push_back('{enc_b(13'd8, 3'b000), 32'h40, 1'b1, 32'h48});
        wait_req(ok, a);
        n_tests++;
        if (!ok || a !== 32'h48) begin
            n_fail++;
            $display("FAIL bht_next got=%h seen=%b want=00000048", a, ok);
        end
        pop_head(ok, got);
        want = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL bht_entry got=%h want=%h", got, want);
        end
    endtask
`else
    task automatic test_branch();
        bit ok;
        logic [31:0] a;
        entry_t got, want;
        logic [31:0] exp_a [3];
        exp_a = '{32'h0, 32'h4, 32'h0};
        do_reset();
        imem[32'h0] = enc_b(13'd8, 3'b000);
        imem[32'h4] = enc_b(13'h1ffc, 3'b001);
        for (int k = 0; k < 3; k++) begin
            wait_req(ok, a);
            n_tests++;
            if (!ok || a !== exp_a[k]) begin
                n_fail++;
                $display("FAIL btfnt_addr[%0d] got=%h seen=%b want=%h", k, a, ok, exp_a[k]);
            end
            if (ok && k < 2) respond(word_at(a));
        end
        sb.push_back('{enc_b(13'd8, 3'b000), 32'h0, 1'b0, 32'h4});
        sb.push_back('{enc_b(13'h1ffc, 3'b001), 32'h4, 1'b1, 32'h0});
        repeat (2) begin
            pop_head(ok, got);
            want = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if (!ok || got !== want) begin
                n_fail++;
                $display("FAIL btfnt_entry got=%h want=%h", got, want);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_fill();
        test_jalr_halt();
        test_flush_wait();
        test_rdy_freeze();
        test_branch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
